sr_cmd_generator: RTL and testbench

Upstream command stage for the SR flip-flop. It takes two raw, bouncy, asynchronous pushbutton inputs (set and reset requests) and synchronizes and debounces each one. It then converts each accepted press into a single-cycle s or r pulse on clk. It guarantees that s and r are never asserted together, so the downstream SR flip-flop never enters its undefined 11 state, and it reports and counts any conflicting simultaneous requests.

---
 rtl/sr_cmd_generator.sv | 111 +++++++++++
 tb/tb_sr_cmd_generator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_generator.sv
// sr_cmd_generator
//   Command front end for an SR flip-flop. Two raw pushbuttons are each
//   passed through a 2-flop synchronizer and a counter debouncer. Each
//   accepted press (debounced rising edge) becomes a one-cycle s or r pulse.
//   s and r are never high in the same cycle. When both presses are accepted
//   together, only the RESET_PRIORITY winner is pulsed, conflict pulses and
//   conflict_cnt counts up, saturating at 255.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   set_btn      in   raw asynchronous set request (1 = pressed)
//   rst_btn      in   raw asynchronous reset request (1 = pressed)
//   s            out  registered one-cycle set pulse
//   r            out  registered one-cycle reset pulse
//   conflict     out  registered one-cycle pulse on a simultaneous press
//   conflict_cnt out  saturating conflict count
//   busy         out  high while either debounce counter is non-zero
module sr_cmd_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          RESET_PRIORITY  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       rst_btn,
  output logic       s,
  output logic       r,
  output logic       conflict,
  output logic [7:0] conflict_cnt,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value from which the next mismatch completes the debounce.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = set, channel 1 = reset.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_prev;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_press;
  logic          w_both;
  logic          w_s_next;
  logic          w_r_next;

  assign w_raw = {rst_btn, set_btn};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync1[g]    <= 1'b0;
        r_sync2[g]    <= 1'b0;
        r_deb[g]      <= 1'b0;
        r_deb_prev[g] <= 1'b0;
        r_cnt[g]      <= '0;
      end else begin
        r_sync1[g]    <= w_raw[g];
        r_sync2[g]    <= r_sync1[g];
        r_deb_prev[g] <= r_deb[g];
        if (r_sync2[g] == r_deb[g]) begin
          r_cnt[g] <= '0;
        end else if (r_cnt[g] == CNT_LAST) begin
          // Level held for DEBOUNCE_CYCLES samples: accept it.
          r_deb[g] <= r_sync2[g];
          r_cnt[g] <= '0;
        end else begin
          r_cnt[g] <= r_cnt[g] + CW'(1);
        end
      end
    end
  end

  assign w_press = r_deb & ~r_deb_prev;
  assign w_both  = w_press[0] & w_press[1];

  // On a simultaneous press the loser is dropped, never queued.
  always_comb begin
    w_s_next = w_press[0];
    w_r_next = w_press[1];
    if (w_both) begin
      if (RESET_PRIORITY) begin
        w_s_next = 1'b0;
      end else begin
        w_r_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s            <= 1'b0;
      r            <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      s        <= w_s_next;
      r        <= w_r_next;
      conflict <= w_both;
      if (w_both && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

  assign busy = (r_cnt[0] != '0) || (r_cnt[1] != '0);

endmodule

// File: tb/tb_sr_cmd_generator.sv
// tb_sr_cmd_generator
//   Drives two instances (RESET_PRIORITY 1 and 0) with the same button
//   stimulus and compares every cycle against a behavioural model: raw
//   samples are delayed two edges, a level is accepted once the last
//   DEBOUNCE_CYCLES samples all differ from the accepted level, and each
//   accepted rising level is pulsed on the following cycle with arbitration.
module tb_sr_cmd_generator;

  localparam int unsigned DC = 4;

  logic       clk;
  logic       rst;
  logic       set_btn;
  logic       rst_btn;
  logic       s1, r1, c1, b1;
  logic [7:0] n1;
  logic       s0, r0, c0, b0;
  logic [7:0] n0;

  sr_cmd_generator #(.DEBOUNCE_CYCLES(DC), .RESET_PRIORITY(1'b1)) u_rp1 (
    .clk(clk), .rst(rst), .set_btn(set_btn), .rst_btn(rst_btn),
    .s(s1), .r(r1), .conflict(c1), .conflict_cnt(n1), .busy(b1)
  );

  sr_cmd_generator #(.DEBOUNCE_CYCLES(DC), .RESET_PRIORITY(1'b0)) u_rp0 (
    .clk(clk), .rst(rst), .set_btn(set_btn), .rst_btn(rst_btn),
    .s(s0), .r(r0), .conflict(c0), .conflict_cnt(n0), .busy(b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_n, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_s1   [2];
  bit m_s2   [2];
  bit m_deb  [2];
  bit m_rose [2];
  bit m_win  [2][$];
  int m_cnt;
  bit e_s1, e_r1, e_s0, e_r0, e_conf, e_busy;

  task automatic model_edge(input bit sb, input bit rb, input bit rs);
    bit press0, press1, both, sv, flip;
    bit raw [2];
    raw[0] = sb;
    raw[1] = rb;
    if (rs) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_rose[c] = 0;
        m_win[c].delete();
      end
      m_cnt = 0;
      e_s1 = 0; e_r1 = 0; e_s0 = 0; e_r0 = 0; e_conf = 0; e_busy = 0;
    end else begin
      press0 = m_rose[0];
      press1 = m_rose[1];
      both   = press0 && press1;
      e_s1   = press0 && !both;
      e_r1   = press1;
      e_s0   = press0;
      e_r0   = press1 && !both;
      e_conf = both;
      if (both && m_cnt < 255) m_cnt++;
      e_busy = 0;
      for (int c = 0; c < 2; c++) begin
        sv = m_s2[c];
        m_win[c].push_back(sv);
        if (m_win[c].size() > DC) void'(m_win[c].pop_front());
        flip = (m_win[c].size() == DC);
        foreach (m_win[c][i]) if (m_win[c][i] == m_deb[c]) flip = 0;
        if (sv != m_deb[c] && !flip) e_busy = 1;
        m_rose[c] = flip && !m_deb[c];
        if (flip) m_deb[c] = !m_deb[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare #1 later.
  task automatic step(input bit sb, input bit rb, input bit rs);
    @(negedge clk);
    set_btn = sb;
    rst_btn = rb;
    rst     = rs;
    @(posedge clk);
    model_edge(sb, rb, rs);
    edge_n++;
    #1;
    chk("s_rp1", int'(s1), int'(e_s1));
    chk("r_rp1", int'(r1), int'(e_r1));
    chk("s_rp0", int'(s0), int'(e_s0));
    chk("r_rp0", int'(r0), int'(e_r0));
    chk("conflict_rp1", int'(c1), int'(e_conf));
    chk("conflict_rp0", int'(c0), int'(e_conf));
    chk("cnt_rp1", int'(n1), m_cnt);
    chk("cnt_rp0", int'(n0), m_cnt);
    chk("busy_rp1", int'(b1), int'(e_busy));
    chk("busy_rp0", int'(b0), int'(e_busy));
    chk("s_and_r_rp1", int'(s1 & r1), 0);
    chk("s_and_r_rp0", int'(s0 & r0), 0);
  endtask

  initial begin
    int k, at, pulses, mode, len;
    bit sb, rb;
    set_btn = 0;
    rst_btn = 0;
    rst     = 1;

    repeat (3) step(0, 0, 1);
    repeat (2) step(0, 0, 0);

    // Held set press: one pulse after edge k+6, nothing more while held.
    k = edge_n + 1; at = -1; pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0);
      if (s1) begin pulses++; at = edge_n - k; end
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      if (s1) pulses++;
    end
    chk("set_latency", at, 6);
    chk("set_pulses", pulses, 1);

    // Glitch train shorter than the debounce window.
    for (int i = 0; i < 10; i++) step(bit'(i % 2 == 0), 0, 0);
    repeat (8) step(0, 0, 0);

    // Simultaneous press.
    repeat (10) step(1, 1, 0);
    repeat (10) step(0, 0, 0);

    // Set press, reset press two cycles later.
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (12) step(1, 1, 0);
    repeat (10) step(0, 0, 0);

    // Reset mid-debounce with rst_btn held through it.
    k = edge_n + 1; at = -1; pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, (i == 3));
      if (r1) begin pulses++; at = edge_n - k; end
    end
    chk("rst_latency", at, 10);
    chk("rst_pulses", pulses, 1);
    repeat (10) step(0, 0, 0);

    // Saturating conflict counter.
    step(0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      repeat (9) step(1, 1, 0);
      repeat (16) step(0, 0, 0);
      if (i >= 254) chk("cnt_sat", int'(n1), (i + 1 > 255) ? 255 : i + 1);
    end

    // Randomized segments.
    for (int seg = 0; seg < 300; seg++) begin
      mode = $urandom_range(0, 9);
      if (mode <= 3) begin
        sb  = bit'($urandom_range(0, 1));
        rb  = bit'($urandom_range(0, 1));
        len = $urandom_range(1, 12);
        repeat (len) step(sb, rb, 0);
      end else if (mode <= 6) begin
        len = $urandom_range(1, 8);
        repeat (len) step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
      end else if (mode == 7) begin
        step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1);
      end else begin
        len = $urandom_range(1, 10);
        repeat (len) step(0, 0, 0);
      end
    end
    repeat (12) step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
